// File: rtl/init_pkg.sv
// Shared types for the RAM init loader: FSM states, preset table entry,
// and the depth helper used to size the clear sweep.
package init_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      PRESET = 2'd2,
      DONE   = 2'd3
   } init_state_t;

   // Table fields are stored wide; the loader keeps only the low bits it needs.
   localparam int unsigned PRESET_FIELD_W = 32;

   typedef struct packed {
      logic [PRESET_FIELD_W-1:0] addr;
      logic [PRESET_FIELD_W-1:0] data;
   } preset_entry_t;

   // Number of words in a RAM with the given address width.
   function automatic int unsigned depth_of(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/init_preset_rom.sv
// Constant table of preset words written into CPU RAM after the clear sweep.
// Entries at or beyond NUM_PRESETS read back as all-zero.
module init_preset_rom
   import init_pkg::*;
#(
   parameter int unsigned NUM_PRESETS = 4,
   parameter int unsigned IDX_W       = 14
) (
   input  logic [IDX_W-1:0] idx,
   output preset_entry_t    entry
);

   logic [31:0] idx_ext;

   assign idx_ext = 32'(idx);

   // Index lookup; later entries that repeat an address overwrite earlier ones in RAM.
   always_comb begin
      entry = '0;
      if (idx_ext < NUM_PRESETS) begin
         case (idx_ext)
            32'd0:   entry = '{addr: 32'h0000_0003, data: 32'h0000_BEEF};
            32'd1:   entry = '{addr: 32'h0000_0003, data: 32'h0000_1234};
            32'd2:   entry = '{addr: 32'h0000_0010, data: 32'h0000_0001};
            32'd3:   entry = '{addr: 32'h0000_0011, data: 32'h0000_0002};
            default: entry = '0;
         endcase
      end
   end

endmodule

// File: rtl/mem_init_loader.sv
// Clears CPU and VGA RAM one word per cycle after reset, then writes the
// preset table into CPU RAM, holding the CPU stalled the whole time.
//
// Control protocol: cpu_hold is high from reset until the first DONE cycle;
// init_done pulses for that single cycle. start is looked at only while in
// DONE, where it relaunches the clear sweep on the next edge; elsewhere it is
// dropped, never remembered.
module mem_init_loader
   import init_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 13,
   parameter int unsigned           DATA_WIDTH  = 16,
   parameter int unsigned           NUM_PRESETS = 4,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  CLK_50,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  cpu_ram_we,
   output logic                  vga_ram_we,
   output logic                  cpu_hold,
   output logic                  init_done
);

   localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
   // One extra bit so the last-address compare never aliases.
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST_CLEAR  = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] LAST_PRESET =
      (NUM_PRESETS == 0) ? '0 : CNT_W'(NUM_PRESETS - 1);

   init_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             first_flag;
   preset_entry_t    rom_entry;
   logic             unused_rom_bits;

   init_preset_rom #(
      .NUM_PRESETS (NUM_PRESETS),
      .IDX_W       (CNT_W)
   ) u_rom (
      .idx   (cnt),
      .entry (rom_entry)
   );

   // Upper table bits beyond the RAM widths are intentionally dropped.
   assign unused_rom_bits = ^{rom_entry.addr[PRESET_FIELD_W-1:ADDR_WIDTH],
                              rom_entry.data[PRESET_FIELD_W-1:DATA_WIDTH]};

   // State, counter and first-DONE-cycle flag registers.
   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         first_flag <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         first_flag <= (state_nxt == DONE) && (state != DONE);
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
         CLEAR: begin
            if (cnt == LAST_CLEAR) begin
               cnt_nxt   = '0;
               state_nxt = (NUM_PRESETS == 0) ? DONE : PRESET;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         PRESET: begin
            if (cnt == LAST_PRESET) begin
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            if (start) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Write port and CPU control decoded from the registered state.
   always_comb begin
      wr_addr    = '0;
      wr_data    = '0;
      cpu_ram_we = 1'b0;
      vga_ram_we = 1'b0;
      cpu_hold   = 1'b1;
      init_done  = 1'b0;
      case (state)
         CLEAR: begin
            wr_addr    = cnt[ADDR_WIDTH-1:0];
            wr_data    = CLEAR_VALUE;
            cpu_ram_we = 1'b1;
            vga_ram_we = 1'b1;
         end
         PRESET: begin
            wr_addr    = rom_entry.addr[ADDR_WIDTH-1:0];
            wr_data    = rom_entry.data[DATA_WIDTH-1:0];
            cpu_ram_we = 1'b1;
         end
         DONE: begin
            cpu_hold  = 1'b0;
            init_done = first_flag;
         end
         default: begin
            cpu_hold = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_init_loader.sv
// Bench for mem_init_loader: small 16-word build with two presets plus a
// preset-free build, both checked against a reference write schedule.
module tb_mem_init_loader;

   localparam int AW         = 4;
   localparam int DW         = 16;
   localparam int NP         = 2;
   localparam int DEPTH      = 16;
   localparam int RUN_EDGES  = DEPTH + NP + 1;
   localparam int RUN0_EDGES = DEPTH + 1;
   localparam int W          = 32 + AW + DW + 2;

   // ---------------- clock / reset ----------------
   logic          CLK_50 = 1'b0;
   logic          reset  = 1'b1;
   logic          start  = 1'b0;
   logic          start0 = 1'b0;
   logic [AW-1:0] wr_addr, wr_addr0;
   logic [DW-1:0] wr_data, wr_data0;
   logic          cpu_ram_we, vga_ram_we, cpu_hold, init_done;
   logic          cpu_ram_we0, vga_ram_we0, cpu_hold0, init_done0;
   int            cyc = 0;

   always #5 CLK_50 = ~CLK_50;
   always @(posedge CLK_50) cyc <= cyc + 1;

   mem_init_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PRESETS(NP)) dut (
      .CLK_50(CLK_50), .reset(reset), .start(start),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_ram_we(cpu_ram_we), .vga_ram_we(vga_ram_we),
      .cpu_hold(cpu_hold), .init_done(init_done)
   );

   mem_init_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PRESETS(0)) dut0 (
      .CLK_50(CLK_50), .reset(reset), .start(start0),
      .wr_addr(wr_addr0), .wr_data(wr_data0),
      .cpu_ram_we(cpu_ram_we0), .vga_ram_we(vga_ram_we0),
      .cpu_hold(cpu_hold0), .init_done(init_done0)
   );

   // ---------------- reference model ----------------
   logic [AW-1:0] p_addr [NP] = '{4'd3, 4'd3};
   logic [DW-1:0] p_data [NP] = '{16'hBEEF, 16'h1234};
   logic [DW-1:0] cpu_ram [DEPTH];
   logic [DW-1:0] vga_ram [DEPTH];

   logic [W-1:0]  exp_q [$];
   logic [31:0]   done_q [$];
   int            done0_exp = 0;
   bit            armed0 = 1'b0;
   int            cpu_we_cnt = 0;
   int            vga_we_cnt = 0;
   int            pass_cnt = 0;
   int            check_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      check_cnt++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // A run launched by stimulus driven at the negedge of cycle 'base':
   // every address cleared on consecutive cycles, then the presets in table order.
   task automatic push_run(input int base);
      for (int a = 0; a < DEPTH; a++)
         exp_q.push_back({32'(base + 1 + a), AW'(a), DW'(0), 1'b1, 1'b1});
      for (int p = 0; p < NP; p++)
         exp_q.push_back({32'(base + 1 + DEPTH + p), p_addr[p], p_data[p], 1'b1, 1'b0});
      done_q.push_back(32'(base + RUN_EDGES));
   endtask

   task automatic prefill(input bit rnd);
      for (int a = 0; a < DEPTH; a++) begin
         cpu_ram[a] = rnd ? DW'($urandom) : 16'hFFFF;
         vga_ram[a] = rnd ? DW'($urandom) : 16'hFFFF;
      end
   endtask

   task automatic ram_check();
      logic [DW-1:0] e;
      for (int a = 0; a < DEPTH; a++) begin
         e = '0;
         for (int p = 0; p < NP; p++)
            if (int'(p_addr[p]) == a) e = p_data[p];
         check($sformatf("cpu_ram[%0d]", a), 64'(cpu_ram[a]), 64'(e));
         check($sformatf("vga_ram[%0d]", a), 64'(vga_ram[a]), 64'(0));
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge CLK_50) begin
      if (!reset) begin
         if (cpu_ram_we || vga_ram_we) begin
            if (cpu_ram_we) begin cpu_ram[wr_addr] = wr_data; cpu_we_cnt++; end
            if (vga_ram_we) begin vga_ram[wr_addr] = wr_data; vga_we_cnt++; end
            if (exp_q.size() == 0) fail_now("unexpected write");
            else check("write {cyc,addr,data,cpu_we,vga_we}",
                       64'({32'(cyc), wr_addr, wr_data, cpu_ram_we, vga_ram_we}),
                       64'(exp_q.pop_front()));
         end
         if (init_done) begin
            if (done_q.size() == 0) fail_now("unexpected init_done");
            else check("init_done cycle", 64'(cyc), 64'(done_q.pop_front()));
         end
         if (cpu_ram_we0) check("np0 cpu_we only in clear", 64'(vga_ram_we0), 64'(1));
         if (init_done0) begin
            if (!armed0) fail_now("np0 unexpected init_done");
            else begin
               check("np0 init_done cycle", 64'(cyc), 64'(done0_exp));
               check("np0 cpu_hold at done", 64'(cpu_hold0), 64'(0));
               armed0 = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic release_reset();
      @(negedge CLK_50);
      reset = 1'b0;
      push_run(cyc);
      done0_exp = cyc + RUN0_EDGES;
      armed0 = 1'b1;
   endtask

   task automatic wait_done(output bit ok, output logic hold_before);
      ok = 1'b0;
      hold_before = 1'bx;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK_50);
         if (init_done) begin ok = 1'b1; break; end
         hold_before = cpu_hold;
      end
      if (!ok) fail_now("timeout waiting for init_done");
   endtask

   task automatic abort_after(input int edges);
      for (int i = 0; i < edges; i++) @(posedge CLK_50);
      #2;
      reset = 1'b1;
      exp_q.delete();
      done_q.delete();
      #1;
      check("abort cpu_ram_we", 64'(cpu_ram_we), 64'(0));
      check("abort vga_ram_we", 64'(vga_ram_we), 64'(0));
      check("abort cpu_hold", 64'(cpu_hold), 64'(1));
      @(negedge CLK_50);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit   ok;
      logic hb;
      int   base;

      // Reset state.
      repeat (3) @(negedge CLK_50);
      check("reset wr_addr", 64'(wr_addr), 64'(0));
      check("reset wr_data", 64'(wr_data), 64'(0));
      check("reset we", 64'({cpu_ram_we, vga_ram_we}), 64'(0));
      check("reset cpu_hold", 64'(cpu_hold), 64'(1));
      check("reset init_done", 64'(init_done), 64'(0));

      // Full init from reset, with a stray start pulse during CLEAR.
      prefill(1'b0);
      cpu_we_cnt = 0;
      vga_we_cnt = 0;
      release_reset();
      repeat ($urandom_range(2, 12)) @(negedge CLK_50);
      start = 1'b1;
      @(negedge CLK_50);
      start = 1'b0;
      wait_done(ok, hb);
      check("hold before done", 64'(hb), 64'(1));
      check("hold at done", 64'(cpu_hold), 64'(0));
      ram_check();
      check("cpu_we count", 64'(cpu_we_cnt), 64'(DEPTH + NP));
      check("vga_we count", 64'(vga_we_cnt), 64'(DEPTH));
      @(negedge CLK_50);
      check("init_done one cycle", 64'(init_done), 64'(0));
      check("hold stays low", 64'(cpu_hold), 64'(0));

      // Reset at CLEAR address 7, then at a random point; restart from address 0.
      @(negedge CLK_50);
      reset = 1'b1;
      @(negedge CLK_50);
      release_reset();
      abort_after(8);
      release_reset();
      abort_after($urandom_range(2, RUN_EDGES - 1));
      prefill(1'b1);
      release_reset();
      wait_done(ok, hb);
      check("hold before done after abort", 64'(hb), 64'(1));
      ram_check();

      // start five cycles into DONE relaunches; start during PRESET is ignored.
      repeat (4) @(negedge CLK_50);
      prefill(1'b1);
      start = 1'b1;
      base = cyc;
      push_run(base);
      @(negedge CLK_50);
      start = 1'b0;
      check("hold after start", 64'(cpu_hold), 64'(1));
      repeat (16) @(negedge CLK_50);
      start = 1'b1;
      @(negedge CLK_50);
      start = 1'b0;
      wait_done(ok, hb);
      ram_check();

      // start held high: back-to-back runs with one DONE cycle each.
      @(negedge CLK_50);
      start = 1'b1;
      push_run(cyc);
      for (int loop = 0; loop < 3; loop++) begin
         wait_done(ok, hb);
         check("loop hold at done", 64'(cpu_hold), 64'(0));
         if (loop < 2) push_run(cyc);
         else start = 1'b0;
         @(negedge CLK_50);
         check("loop hold after done", 64'(cpu_hold), 64'(loop < 2));
      end
      repeat (4) @(negedge CLK_50);

      check("leftover writes", 64'(exp_q.size()), 64'(0));
      check("leftover init_done", 64'(done_q.size()), 64'(0));
      check("np0 done seen", 64'(armed0), 64'(0));
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
      $fatal(1);
   end

endmodule
